// File: rtl/ppm_out_bank.sv
// ppm_out_bank: NCH phase-aligned ESC pulse outputs with double-buffered commands.
// Optional macro PPM_WDOG_EN adds a failsafe-idle watchdog on stale commands.
module ppm_out_bank #(
    parameter int NCH      = 4,
    parameter int VAL_W    = 10,
    parameter int MIN_US   = 1000,
    parameter int MAX_US   = 2000,
    parameter int FRAME_US = 2251,
    parameter int WDOG_FR  = 8
) (
    input  logic                 CLK_1M,
    input  logic                 RST_N,
    input  logic [NCH*VAL_W-1:0] VAL,
    input  logic                 LOAD,
    input  logic                 ARM,
    output logic [NCH-1:0]       PPM,
    output logic                 FRAME_STB,
    output logic                 PENDING
);

    localparam int CW = 12;
    localparam logic [CW-1:0] MIN_W = CW'(MIN_US);
    localparam logic [CW-1:0] MAX_W = CW'(MAX_US);
    localparam logic [CW-1:0] LAST  = CW'(FRAME_US - 1);

    logic [CW-1:0]    cnt;
    logic             wrap;
    logic             arm_r;
    logic             idle;
    logic [VAL_W-1:0] shadow [NCH];
    logic [CW-1:0]    width  [NCH];
    logic [CW-1:0]    sum    [NCH];
    logic [CW-1:0]    nxt_w  [NCH];
    logic [CW-1:0]    eff    [NCH];

    assign wrap = (cnt == LAST);

    // Shared frame counter and the registered frame strobe
    always_ff @(posedge CLK_1M or negedge RST_N) begin
        if (!RST_N) begin
            cnt       <= '0;
            FRAME_STB <= 1'b0;
        end else begin
            cnt       <= wrap ? '0 : cnt + 1'b1;
            FRAME_STB <= (cnt == '0);
        end
    end

    // Shadow capture; a LOAD on the wrap cycle keeps PENDING for the next frame
    always_ff @(posedge CLK_1M or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < NCH; i++) shadow[i] <= '0;
            PENDING <= 1'b0;
        end else if (LOAD) begin
            for (int i = 0; i < NCH; i++) shadow[i] <= VAL[i*VAL_W +: VAL_W];
            PENDING <= 1'b1;
        end else if (wrap) begin
            PENDING <= 1'b0;
        end
    end

    // Clamped widths from shadow and the effective width per channel
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            sum[i]   = CW'(shadow[i]) + MIN_W;
            nxt_w[i] = (sum[i] > MAX_W) ? MAX_W : sum[i];
            eff[i]   = (arm_r && !idle) ? width[i] : MIN_W;
        end
    end

    // Commit arm state and pending widths only at the frame boundary
    always_ff @(posedge CLK_1M or negedge RST_N) begin
        if (!RST_N) begin
            arm_r <= 1'b0;
            for (int i = 0; i < NCH; i++) width[i] <= MIN_W;
        end else if (wrap) begin
            arm_r <= ARM;
            if (PENDING) begin
                for (int i = 0; i < NCH; i++) width[i] <= nxt_w[i];
            end
        end
    end

`ifdef PPM_WDOG_EN
    localparam int WW = $clog2(WDOG_FR + 1);
    logic [WW-1:0] wdog;

    assign idle = (wdog == WW'(WDOG_FR));

    // Boundaries since the last committed LOAD; cleared at the commit so a
    // restored width never appears in the middle of a frame
    always_ff @(posedge CLK_1M or negedge RST_N) begin
        if (!RST_N) begin
            wdog <= '0;
        end else if (wrap) begin
            if (PENDING)    wdog <= '0;
            else if (!idle) wdog <= wdog + 1'b1;
        end
    end
`else
    assign idle = (WDOG_FR < 0);
`endif

    // Registered pulse outputs, high while the count is below the width
    always_ff @(posedge CLK_1M or negedge RST_N) begin
        if (!RST_N) begin
            PPM <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) PPM[i] <= (cnt < eff[i]);
        end
    end

endmodule

// File: tb/tb_ppm_out_bank.sv
// tb_ppm_out_bank: frame-by-frame pulse measurement against a queue of
// expected per-channel widths pushed as stimulus is applied.
`timescale 1ns/1ps
module tb_ppm_out_bank;

    localparam int NCH   = 4;
    localparam int VAL_W = 10;

    logic                 CLK_1M = 1'b0;
    logic                 RST_N  = 1'b0;
    logic [NCH*VAL_W-1:0] VAL    = '0;
    logic                 LOAD   = 1'b0;
    logic                 ARM    = 1'b0;
    logic [NCH-1:0]       PPM;
    logic                 FRAME_STB;
    logic                 PENDING;

    int compared   = 0;
    int mismatched = 0;
    logic [NCH*12-1:0] exp_q [$];

    always #500 CLK_1M = ~CLK_1M;

    ppm_out_bank dut (
        .CLK_1M    (CLK_1M),
        .RST_N     (RST_N),
        .VAL       (VAL),
        .LOAD      (LOAD),
        .ARM       (ARM),
        .PPM       (PPM),
        .FRAME_STB (FRAME_STB),
        .PENDING   (PENDING)
    );

    function automatic int model_w(int v);
        int s;
        s = 1000 + v;
        return (s > 2000) ? 2000 : s;
    endfunction

    function automatic logic [NCH*VAL_W-1:0] pack(int v3, int v2, int v1, int v0);
        return {VAL_W'(v3), VAL_W'(v2), VAL_W'(v1), VAL_W'(v0)};
    endfunction

    function automatic logic [NCH*12-1:0] wv(int w3, int w2, int w1, int w0);
        return {12'(w3), 12'(w2), 12'(w1), 12'(w0)};
    endfunction

    task automatic do_load(logic [NCH*VAL_W-1:0] v);
        VAL  = v;
        LOAD = 1'b1;
        @(negedge CLK_1M);
        LOAD = 1'b0;
    endtask

    task automatic sync_frame();
        int n;
        n = 0;
        while (FRAME_STB !== 1'b1 && n < 5000) begin
            @(negedge CLK_1M);
            n++;
        end
        compared++;
        if (FRAME_STB !== 1'b1) begin
            mismatched++;
            $display("FAIL sync: FRAME_STB=%b after %0d cycles, need 1", FRAME_STB, n);
        end
    endtask

    // Called on the negedge where FRAME_STB is high; returns on the next one.
    task automatic measure_frame();
        int period;
        int hi [NCH];
        logic [NCH*12-1:0] e;
        period = 0;
        for (int i = 0; i < NCH; i++) hi[i] = 0;
        compared++;
        if (PPM !== {NCH{1'b1}}) begin
            mismatched++;
            $display("FAIL align: PPM=%b at frame start, need %b", PPM, {NCH{1'b1}});
        end
        do begin
            for (int i = 0; i < NCH; i++) if (PPM[i] === 1'b1) hi[i]++;
            period++;
            @(negedge CLK_1M);
        end while (FRAME_STB !== 1'b1 && period < 5000);
        compared++;
        if (period != 2251) begin
            mismatched++;
            $display("FAIL period: got %0d cycles, need 2251", period);
        end
        compared++;
        if (exp_q.size() == 0) begin
            mismatched++;
            $display("FAIL scoreboard: frame measured with no expectation queued");
        end else begin
            e = exp_q.pop_front();
            for (int i = 0; i < NCH; i++) begin
                compared++;
                if (hi[i] != int'(e[i*12 +: 12])) begin
                    mismatched++;
                    $display("FAIL width ch%0d: got %0d, need %0d", i, hi[i], int'(e[i*12 +: 12]));
                end
            end
        end
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        repeat (3) @(negedge CLK_1M);
        compared++;
        if (PPM !== '0) begin
            mismatched++;
            $display("FAIL reset_ppm: got %b, need 0", PPM);
        end
        compared++;
        if (FRAME_STB !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_stb: got %b, need 0", FRAME_STB);
        end
        compared++;
        if (PENDING !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_pending: got %b, need 0", PENDING);
        end
        RST_N = 1'b1;
        @(negedge CLK_1M);
        compared++;
        if (FRAME_STB !== 1'b1) begin
            mismatched++;
            $display("FAIL first_stb: got %b, need 1", FRAME_STB);
        end
        sync_frame();
        exp_q.push_back(wv(1000, 1000, 1000, 1000));
        exp_q.push_back(wv(1000, 1000, 1000, 1000));
        measure_frame();
        measure_frame();
    endtask

    task automatic test_arm_load();
        ARM = 1'b1;
        exp_q.push_back(wv(1000, 1000, 1000, 1000));
        fork
            measure_frame();
            begin
                repeat (500) @(negedge CLK_1M);
                do_load(pack(0, 500, 1000, 1023));
                exp_q.push_back(wv(model_w(0), model_w(500), model_w(1000), model_w(1023)));
                compared++;
                if (PENDING !== 1'b1) begin
                    mismatched++;
                    $display("FAIL pending_set: got %b, need 1", PENDING);
                end
            end
        join
        compared++;
        if (PENDING !== 1'b0) begin
            mismatched++;
            $display("FAIL pending_clr: got %b, need 0", PENDING);
        end
        measure_frame();
    endtask

    task automatic test_two_loads();
        exp_q.push_back(wv(1000, 1500, 2000, 2000));
        fork
            measure_frame();
            begin
                repeat (300) @(negedge CLK_1M);
                do_load(pack(0, 0, 0, 100));
                repeat (300) @(negedge CLK_1M);
                do_load(pack(0, 0, 0, 200));
                exp_q.push_back(wv(1000, 1000, 1000, model_w(200)));
            end
        join
    endtask

    task automatic test_load_on_wrap();
        fork
            measure_frame();
            begin
                repeat (500) @(negedge CLK_1M);
                do_load(pack(0, 0, 0, 50));
                repeat (1748) @(negedge CLK_1M);
                do_load(pack(0, 0, 0, 300));
                exp_q.push_back(wv(1000, 1000, 1000, model_w(50)));
                exp_q.push_back(wv(1000, 1000, 1000, model_w(300)));
                compared++;
                if (PENDING !== 1'b1) begin
                    mismatched++;
                    $display("FAIL wrap_pending: got %b, need 1", PENDING);
                end
            end
        join
        compared++;
        if (PENDING !== 1'b1) begin
            mismatched++;
            $display("FAIL wrap_pending_next: got %b, need 1", PENDING);
        end
        measure_frame();
        compared++;
        if (PENDING !== 1'b0) begin
            mismatched++;
            $display("FAIL wrap_pending_done: got %b, need 0", PENDING);
        end
        measure_frame();
    endtask

    task automatic test_arm_drop();
        exp_q.push_back(wv(1000, 1000, 1000, 1300));
        fork
            measure_frame();
            begin
                repeat (700) @(negedge CLK_1M);
                ARM = 1'b0;
                exp_q.push_back(wv(1000, 1000, 1000, 1000));
            end
        join
        fork
            measure_frame();
            begin
                repeat (700) @(negedge CLK_1M);
                ARM = 1'b1;
                exp_q.push_back(wv(1000, 1000, 1000, 1300));
            end
        join
        measure_frame();
    endtask

    task automatic test_reset_mid();
        repeat (10) @(negedge CLK_1M);
        compared++;
        if (PPM !== {NCH{1'b1}}) begin
            mismatched++;
            $display("FAIL pre_reset_ppm: got %b, need 1111", PPM);
        end
        RST_N = 1'b0;
        #1;
        compared++;
        if (PPM !== '0 || FRAME_STB !== 1'b0 || PENDING !== 1'b0) begin
            mismatched++;
            $display("FAIL async_reset: PPM=%b STB=%b PENDING=%b, need 0/0/0", PPM, FRAME_STB, PENDING);
        end
        @(negedge CLK_1M);
        RST_N = 1'b1;
        sync_frame();
        exp_q.push_back(wv(1000, 1000, 1000, 1000));
        exp_q.push_back(wv(1000, 1000, 1000, 1000));
        measure_frame();
        measure_frame();
    endtask

`ifdef PPM_WDOG_EN
    task automatic test_wdog();
        exp_q.push_back(wv(1000, 1000, 1000, 1000));
        fork
            measure_frame();
            begin
                repeat (500) @(negedge CLK_1M);
                do_load(pack(0, 0, 0, 400));
                repeat (8) exp_q.push_back(wv(1000, 1000, 1000, 1400));
                repeat (2) exp_q.push_back(wv(1000, 1000, 1000, 1000));
            end
        join
        repeat (10) measure_frame();
        exp_q.push_back(wv(1000, 1000, 1000, 1000));
        fork
            measure_frame();
            begin
                repeat (500) @(negedge CLK_1M);
                do_load(pack(0, 0, 0, 400));
                exp_q.push_back(wv(1000, 1000, 1000, 1400));
            end
        join
        measure_frame();
    endtask
`endif

    initial begin
        test_reset();
        test_arm_load();
        test_two_loads();
        test_load_on_wrap();
        test_arm_drop();
        test_reset_mid();
`ifdef PPM_WDOG_EN
        test_wdog();
`endif
        compared++;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL leftover: %0d expectations unconsumed, need 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
